// File: rtl/sha256_round_ctrl_pkg.sv
// Shared definitions for the SHA-256 round controller.
// Contents: round/message-word counts, round-index width, FSM state encoding.
package sha256_round_ctrl_pkg;

    localparam int unsigned SHA_ROUNDS    = 64;
    localparam int unsigned SHA_MSG_WORDS = 16;
    localparam int unsigned ROUND_W       = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_IV    = 3'd1,
        ST_LOADW = 3'd2,
        ST_ROUND = 3'd3,
        ST_ADD   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/sha256_round_ctrl_round_counter.sv
// Round index counter for the SHA-256 controller.
// Ports:
//   clk, clear (synchronous, active-high), en (advance one round)
//   count   : current round index
//   is_last : count is the final round (wraps to 0 on the next enable)
//   is_msg  : count is within the message-word rounds
module sha256_round_counter
    import sha256_round_ctrl_pkg::*;
#(
    parameter int unsigned ROUNDS    = SHA_ROUNDS,
    parameter int unsigned MSG_WORDS = SHA_MSG_WORDS
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               en,
    output logic [ROUND_W-1:0] count,
    output logic               is_last,
    output logic               is_msg
);

    // Wrap on the last round so the index never leaves 0..ROUNDS-1.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= is_last ? '0 : count + ROUND_W'(1);
        end
    end

    assign is_last = (count == ROUND_W'(ROUNDS - 1));
    assign is_msg  = (count < ROUND_W'(MSG_WORDS));

endmodule

// File: rtl/sha256_round_ctrl.sv
// Sequencer for one SHA-256 compression of a 512-bit block.
// Ports:
//   clk, rst (synchronous, active-high)
//   start, first_block      : block request; first_block selects IV load
//   ready, busy             : idle / in progress
//   w_valid, w_ready        : message word handshake (rounds 0..15)
//   round_n                 : round index for the constant lookup
//   w_sel_msg, round_en     : schedule source select, round execute
//   init_hv, init_work      : load IV into H, load a..h from H
//   add_hv, done            : final H accumulate, digest-valid pulse
module sha256_round_ctrl
    import sha256_round_ctrl_pkg::*;
#(
    parameter int unsigned ROUNDS    = SHA_ROUNDS,
    parameter int unsigned MSG_WORDS = SHA_MSG_WORDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               first_block,
    output logic               ready,
    output logic               busy,
    input  logic               w_valid,
    output logic               w_ready,
    output logic [ROUND_W-1:0] round_n,
    output logic               w_sel_msg,
    output logic               round_en,
    output logic               init_hv,
    output logic               init_work,
    output logic               add_hv,
    output logic               done
);

    state_t state;
    logic   in_round;
    logic   is_last;
    logic   is_msg;

    sha256_round_counter #(
        .ROUNDS    (ROUNDS),
        .MSG_WORDS (MSG_WORDS)
    ) u_counter (
        .clk     (clk),
        .clear   (rst),
        .en      (round_en),
        .count   (round_n),
        .is_last (is_last),
        .is_msg  (is_msg)
    );

    // Message rounds wait on w_valid; expanded rounds run every cycle.
    assign w_sel_msg = in_round & is_msg;
    assign w_ready   = w_sel_msg;
    assign round_en  = in_round & (~is_msg | w_valid);

    // State register with outputs registered alongside the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            in_round  <= 1'b0;
            init_hv   <= 1'b0;
            init_work <= 1'b0;
            add_hv    <= 1'b0;
            done      <= 1'b0;
        end else begin
            init_hv   <= 1'b0;
            init_work <= 1'b0;
            add_hv    <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        if (first_block) begin
                            state   <= ST_IV;
                            init_hv <= 1'b1;
                        end else begin
                            state     <= ST_LOADW;
                            init_work <= 1'b1;
                        end
                    end
                end
                ST_IV: begin
                    state     <= ST_LOADW;
                    init_work <= 1'b1;
                end
                ST_LOADW: begin
                    state    <= ST_ROUND;
                    in_round <= 1'b1;
                end
                ST_ROUND: begin
                    if (round_en && is_last) begin
                        state    <= ST_ADD;
                        in_round <= 1'b0;
                        add_hv   <= 1'b1;
                    end
                end
                ST_ADD: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    ready    <= 1'b1;
                    busy     <= 1'b0;
                    in_round <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: a timeline model of expected
// outputs per cycle, a behavioural SHA-256 datapath driven by the DUT
// enables for digest checks, and literal latency expectations.
module tb_sha256_round_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, first_block, w_valid;
    logic       ready, busy, w_ready, w_sel_msg, round_en;
    logic       init_hv, init_work, add_hv, done;
    logic [5:0] round_n;

    always #5 clk = ~clk;

    sha256_round_ctrl dut (
        .clk (clk), .rst (rst), .start (start), .first_block (first_block),
        .ready (ready), .busy (busy), .w_valid (w_valid), .w_ready (w_ready),
        .round_n (round_n), .w_sel_msg (w_sel_msg), .round_en (round_en),
        .init_hv (init_hv), .init_work (init_work), .add_hv (add_hv), .done (done)
    );

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Behavioural datapath, sequenced only by the DUT enables.
    logic [31:0] hv [8];
    logic [31:0] wk [8];
    logic [31:0] wwin [16];
    logic [31:0] msg [16];
    logic [31:0] wt, t1, t2;

    assign wt = w_sel_msg ? msg[round_n[3:0]]
              : (rotr(wwin[14], 17) ^ rotr(wwin[14], 19) ^ (wwin[14] >> 10)) + wwin[9]
              + (rotr(wwin[1], 7) ^ rotr(wwin[1], 18) ^ (wwin[1] >> 3)) + wwin[0];
    assign t1 = wk[7] + (rotr(wk[4], 6) ^ rotr(wk[4], 11) ^ rotr(wk[4], 25))
              + ((wk[4] & wk[5]) ^ (~wk[4] & wk[6])) + K[round_n] + wt;
    assign t2 = (rotr(wk[0], 2) ^ rotr(wk[0], 13) ^ rotr(wk[0], 22))
              + ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));

    always @(posedge clk) begin
        if (init_hv) for (int i = 0; i < 8; i++) hv[i] <= IV[i];
        if (init_work) for (int i = 0; i < 8; i++) wk[i] <= hv[i];
        if (round_en) begin
            wk[7] <= wk[6]; wk[6] <= wk[5]; wk[5] <= wk[4]; wk[4] <= wk[3] + t1;
            wk[3] <= wk[2]; wk[2] <= wk[1]; wk[1] <= wk[0]; wk[0] <= t1 + t2;
            for (int i = 0; i < 15; i++) wwin[i] <= wwin[i + 1];
            wwin[15] <= wt;
        end
        if (add_hv) for (int i = 0; i < 8; i++) hv[i] <= hv[i] + wk[i];
    end

    // One expected output vector per cycle; wv is the w_valid to drive.
    typedef struct packed {
        logic [5:0] rn;
        logic ready, wsel, wr, ren, ihv, iw, add, dn, wv;
    } exp_t;

    exp_t q [$];
    int   stall_plan [16];
    int   errors = 0, checks = 0, cyc = 0, accept_cyc = 0;
    int   n_done = 0, n_add = 0, multi_strobe = 0, add_rn = 0;
    int   blk_done, blk_ihv, blk_ihv_cyc, blk_iw_cyc, blk_add_cyc, blk_done_cyc;
    int   blk_wr, blk_wr_first, blk_wr_last;

    function automatic exp_t mk(input logic [5:0] rn, input logic rdy, input logic wsel,
                                input logic wr, input logic ren, input logic ihv,
                                input logic iw, input logic add, input logic dn, input logic wv);
        exp_t e;
        e = '{rn: rn, ready: rdy, wsel: wsel, wr: wr, ren: ren, ihv: ihv,
              iw: iw, add: add, dn: dn, wv: wv};
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Expected timeline of one block from the cycle after the accept edge.
    function automatic void plan_block(input logic fb);
        if (fb) q.push_back(mk(6'd0, 0, 0, 0, 0, 1, 0, 0, 0, rb()));
        q.push_back(mk(6'd0, 0, 0, 0, 0, 0, 1, 0, 0, rb()));
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                for (int s = 0; s < stall_plan[t]; s++)
                    q.push_back(mk(6'(t), 0, 1, 1, 0, 0, 0, 0, 0, 1'b0));
                q.push_back(mk(6'(t), 0, 1, 1, 1, 0, 0, 0, 0, 1'b1));
            end else begin
                q.push_back(mk(6'(t), 0, 0, 0, 1, 0, 0, 0, 0, (t == 40) ? 1'b1 : rb()));
            end
        end
        q.push_back(mk(6'd0, 0, 0, 0, 0, 0, 0, 1, 0, rb()));
        q.push_back(mk(6'd0, 0, 0, 0, 0, 0, 0, 0, 1, rb()));
    endfunction

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void compare(input exp_t e);
        checks++;
        if ({round_n, ready, w_sel_msg, w_ready, round_en, init_hv, init_work, add_hv, done, busy} !==
            {e.rn, e.ready, e.wsel, e.wr, e.ren, e.ihv, e.iw, e.add, e.dn, ~e.ready}) begin
            errors++;
            $display("FAIL cycle %0d outputs: got rn=%0d rdy=%b bsy=%b sel=%b wr=%b en=%b ihv=%b iw=%b add=%b dn=%b expected rn=%0d rdy=%b sel=%b wr=%b en=%b ihv=%b iw=%b add=%b dn=%b",
                     cyc, round_n, ready, busy, w_sel_msg, w_ready, round_en, init_hv, init_work, add_hv, done,
                     e.rn, e.ready, e.wsel, e.wr, e.ren, e.ihv, e.iw, e.add, e.dn);
        end
        if (int'(init_hv) + int'(init_work) + int'(round_en) + int'(add_hv) > 1) multi_strobe++;
        if (done === 1'b1) begin n_done++; blk_done++; blk_done_cyc = cyc; end
        if (add_hv === 1'b1) begin n_add++; blk_add_cyc = cyc; add_rn = int'(round_n); end
        if (init_hv === 1'b1) begin blk_ihv++; blk_ihv_cyc = cyc; end
        if (init_work === 1'b1) blk_iw_cyc = cyc;
        if (w_ready === 1'b1) begin
            blk_wr++;
            if (blk_wr_first < 0) blk_wr_first = cyc;
            blk_wr_last = cyc;
        end
    endfunction

    task automatic step(input logic do_start, input logic fb, input logic do_rst);
        exp_t e;
        @(negedge clk);
        e = (q.size() != 0) ? q[0] : mk(6'd0, 1, 0, 0, 0, 0, 0, 0, 0, rb());
        rst = do_rst; start = do_start; first_block = fb; w_valid = e.wv;
        #1;
        compare(e);
        @(posedge clk);
        if (q.size() != 0) void'(q.pop_front());
        if (do_rst) begin
            q.delete();
        end else if (e.ready && do_start) begin
            plan_block(fb);
            accept_cyc = cyc;
            blk_done = 0; blk_ihv = 0; blk_wr = 0; blk_wr_first = -1; blk_wr_last = -1;
            blk_ihv_cyc = -1; blk_iw_cyc = -1; blk_add_cyc = -1; blk_done_cyc = -1;
        end
        cyc++;
    endtask

    task automatic run_idle();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            step(1'b0, rb(), 1'b0);
            n++;
        end
        chk("block_completes", 256'(q.size()), 256'd0);
    endtask

    task automatic clear_stalls();
        for (int i = 0; i < 16; i++) stall_plan[i] = 0;
    endtask

    function automatic logic [255:0] digest();
        return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; first_block = 1'b0; w_valid = 1'b0;
        clear_stalls();
        repeat (2) @(posedge clk);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // "abc" single block, no stalls
        msg = '{32'h61626380, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000018};
        step(1'b1, 1'b1, 1'b0);
        run_idle();
        chk("abc_init_hv_cycle",   256'(blk_ihv_cyc - accept_cyc), 256'd1);
        chk("abc_init_work_cycle", 256'(blk_iw_cyc - accept_cyc), 256'd2);
        chk("abc_w_ready_count",   256'(blk_wr), 256'd16);
        chk("abc_first_w_ready",   256'(blk_wr_first - accept_cyc), 256'd3);
        chk("abc_last_w_ready",    256'(blk_wr_last - accept_cyc), 256'd18);
        chk("abc_add_cycle",       256'(blk_add_cyc - accept_cyc), 256'd67);
        chk("abc_done_cycle",      256'(blk_done_cyc - accept_cyc), 256'd68);
        chk("add_round_n_wrapped", 256'(add_rn), 256'd0);
        chk("abc_digest", digest(),
            256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        // Two-block message, second block chained in the first ready cycle
        msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
                32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        step(1'b1, 1'b1, 1'b0);
        run_idle();
        msg = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h000001c0};
        step(1'b1, 1'b0, 1'b0);
        run_idle();
        chk("chain_no_init_hv", 256'(blk_ihv), 256'd0);
        chk("chain_done_cycle", 256'(blk_done_cyc - accept_cyc), 256'd67);
        chk("chain_digest", digest(),
            256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);

        // Three-cycle message stall at round 5
        stall_plan[5] = 3;
        step(1'b1, 1'b1, 1'b0);
        run_idle();
        chk("stall_done_cycle", 256'(blk_done_cyc - accept_cyc), 256'd71);
        clear_stalls();

        // start pulsed at round 30 (w_valid pulse at round 40 is in the plan)
        step(1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 400 && q.size() != 0; n++)
            step(1'(q[0].ren && !q[0].wsel && q[0].rn == 6'd30), rb(), 1'b0);
        chk("ignored_start_one_done", 256'(blk_done), 256'd1);

        // Reset held two cycles at round 20
        step(1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 200 && !(q.size() != 0 && q[0].rn == 6'd20 && !q[0].wsel); n++)
            step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        begin
            int d0, a0;
            d0 = n_done; a0 = n_add;
            repeat (80) step(1'b0, rb(), 1'b0);
            chk("reset_no_done", 256'(n_done - d0), 256'd0);
            chk("reset_no_add",  256'(n_add - a0), 256'd0);
        end

        // Randomised traffic with stalls, stray starts and occasional reset
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 16; i++)
                stall_plan[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 0;
            step(1'($urandom_range(0, 2) == 0), rb(), 1'($urandom_range(0, 499) == 0));
        end
        clear_stalls();
        run_idle();
        chk("strobes_exclusive", 256'(multi_strobe), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
